// File: rtl/pulse_loopback_checker.sv
// Loopback pulse checker: timestamps outgoing pulses, matches returns in order,
// and reports round-trip latency, loss-by-timeout and protocol errors.
module pulse_loopback_checker #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TS_W    = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pulse_snd,
    input  logic                    pulse_rcv,
    input  logic                    clr_stats,
    output logic [CNT_W-1:0]        count_snd,
    output logic [CNT_W-1:0]        count_rcv,
    output logic [CNT_W-1:0]        count_lost,
    output logic [$clog2(DEPTH):0]  outstanding,
    output logic                    lat_valid,
    output logic [TS_W-1:0]         lat_last,
    output logic [TS_W-1:0]         lat_min,
    output logic [TS_W-1:0]         lat_max,
    output logic                    err_spurious,
    output logic                    err_overflow,
    output logic                    err_timeout
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    logic [TS_W-1:0] head_age_c;
    logic            empty_c;
    logic            full_c;
    logic            match_c;
    logic            lost_c;
    logic            pop_c;
    logic            push_c;
    logic            ovf_c;
    logic            spur_c;

    // Per-cycle event decode; a timeout pop frees a slot just like a matched return.
    always_comb begin
        empty_c    = (wr_ptr == rd_ptr);
        full_c     = ((wr_ptr - rd_ptr) == PW'(DEPTH));
        head_age_c = ts - mem[rd_ptr[AW-1:0]];
        match_c    = pulse_rcv && !empty_c;
        lost_c     = !pulse_rcv && !empty_c && (head_age_c >= TS_W'(TIMEOUT));
        pop_c      = match_c || lost_c;
        push_c     = pulse_snd && (!full_c || pop_c);
        ovf_c      = pulse_snd && full_c && !pop_c;
        spur_c     = pulse_rcv && empty_c;
    end

    // Timestamp and FIFO pointers; untouched by clr_stats.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts          <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            ts          <= ts + TS_W'(1);
            if (push_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
            outstanding <= outstanding + PW'(push_c) - PW'(pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_c) mem[wr_ptr[AW-1:0]] <= ts;
    end

    // Statistics and sticky flags; clr_stats wins over any same-cycle update.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            count_snd    <= '0;
            count_rcv    <= '0;
            count_lost   <= '0;
            lat_valid    <= 1'b0;
            lat_last     <= '0;
            lat_min      <= '1;
            lat_max      <= '0;
            err_spurious <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            lat_valid <= match_c;
            if (push_c) count_snd  <= count_snd + CNT_W'(1);
            if (lost_c) count_lost <= count_lost + CNT_W'(1);
            if (match_c) begin
                count_rcv <= count_rcv + CNT_W'(1);
                lat_last  <= head_age_c;
                if (head_age_c < lat_min) lat_min <= head_age_c;
                if (head_age_c > lat_max) lat_max <= head_age_c;
            end
            if (spur_c) err_spurious <= 1'b1;
            if (ovf_c)  err_overflow <= 1'b1;
            if (lost_c) err_timeout  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pulse_loopback_checker.sv
// Bench for pulse_loopback_checker: queue-based reference model checked every cycle,
// a vector table for FIFO full/empty corners, and directed latency/timeout/wrap sequences.
module tb_pulse_loopback_checker;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned TS_W      = 16;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned TIMEOUT   = 40;
    localparam int unsigned TIMEOUT_S = 16;
    localparam int unsigned PW        = $clog2(DEPTH) + 1;
    localparam int unsigned SW        = 3*CNT_W + PW + 1 + 3*TS_W + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, pulse_snd, pulse_rcv, clr_stats;

    logic [CNT_W-1:0] a_cs, a_cr, a_cl;
    logic [PW-1:0]    a_out;
    logic             a_lv;
    logic [TS_W-1:0]  a_ll, a_lmin, a_lmax;
    logic             a_es, a_eo, a_et;

    logic [CNT_W-1:0] b_cs, b_cr, b_cl;
    logic [PW-1:0]    b_out;
    logic             b_lv;
    logic [TS_W-1:0]  b_ll, b_lmin, b_lmax;
    logic             b_es, b_eo, b_et;

    pulse_loopback_checker #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .pulse_snd(pulse_snd), .pulse_rcv(pulse_rcv), .clr_stats(clr_stats),
        .count_snd(a_cs), .count_rcv(a_cr), .count_lost(a_cl), .outstanding(a_out),
        .lat_valid(a_lv), .lat_last(a_ll), .lat_min(a_lmin), .lat_max(a_lmax),
        .err_spurious(a_es), .err_overflow(a_eo), .err_timeout(a_et)
    );

    // Short-timeout instance, only checked in the timeout sequence.
    pulse_loopback_checker #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT_S)) dut_s (
        .clk(clk), .rst(rst), .pulse_snd(pulse_snd), .pulse_rcv(pulse_rcv), .clr_stats(clr_stats),
        .count_snd(b_cs), .count_rcv(b_cr), .count_lost(b_cl), .outstanding(b_out),
        .lat_valid(b_lv), .lat_last(b_ll), .lat_min(b_lmin), .lat_max(b_lmax),
        .err_spurious(b_es), .err_overflow(b_eo), .err_timeout(b_et)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [TS_W-1:0]  m_ts;
    logic [TS_W-1:0]  m_q [$];
    logic [CNT_W-1:0] m_cs, m_cr, m_cl;
    logic             m_lv;
    logic [TS_W-1:0]  m_ll, m_lmin, m_lmax;
    logic             m_es, m_eo, m_et;

    task automatic model_clear_stats();
        m_cs = '0; m_cr = '0; m_cl = '0; m_lv = 1'b0;
        m_ll = '0; m_lmin = '1; m_lmax = '0;
        m_es = 1'b0; m_eo = 1'b0; m_et = 1'b0;
    endtask

    task automatic model_step(input logic snd, input logic rcv, input logic clr, input logic rs);
        logic [TS_W-1:0] age;
        logic matched, lost, pushed, spur, ovf;
        if (rs) begin
            m_q.delete();
            m_ts = '0;
            model_clear_stats();
            return;
        end
        matched = 1'b0; lost = 1'b0; pushed = 1'b0; spur = 1'b0; ovf = 1'b0;
        age = '0;
        if (m_q.size() != 0) age = m_ts - m_q[0];
        if (rcv) begin
            if (m_q.size() != 0) begin
                void'(m_q.pop_front());
                matched = 1'b1;
            end else begin
                spur = 1'b1;
            end
        end else if (m_q.size() != 0 && 32'(age) >= TIMEOUT) begin
            void'(m_q.pop_front());
            lost = 1'b1;
        end
        if (snd) begin
            if (m_q.size() < int'(DEPTH)) begin
                m_q.push_back(m_ts);
                pushed = 1'b1;
            end else begin
                ovf = 1'b1;
            end
        end
        if (clr) begin
            model_clear_stats();
        end else begin
            m_lv = matched;
            if (pushed) m_cs = m_cs + CNT_W'(1);
            if (lost)   m_cl = m_cl + CNT_W'(1);
            if (matched) begin
                m_cr = m_cr + CNT_W'(1);
                m_ll = age;
                if (age < m_lmin) m_lmin = age;
                if (age > m_lmax) m_lmax = age;
            end
            m_es = m_es | spur;
            m_eo = m_eo | ovf;
            m_et = m_et | lost;
        end
        m_ts = m_ts + TS_W'(1);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [SW-1:0] act, exp;
        act = {a_cs, a_cr, a_cl, a_out, a_lv, a_ll, a_lmin, a_lmax, a_es, a_eo, a_et};
        exp = {m_cs, m_cr, m_cl, PW'(m_q.size()), m_lv, m_ll, m_lmin, m_lmax, m_es, m_eo, m_et};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL model_state: got %h expected %h (t=%0t)", act, exp, $time);
        end
    endtask

    task automatic cycle(input logic snd, input logic rcv, input logic clr, input logic rs);
        pulse_snd = snd; pulse_rcv = rcv; clr_stats = clr; rst = rs;
        @(posedge clk);
        model_step(snd, rcv, clr, rs);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    typedef struct packed {
        logic       snd;
        logic       rcv;
        logic       clr;
        logic [2:0] out;
        logic [7:0] cs;
        logic [7:0] cr;
        logic       eo;
        logic       es;
    } vec_t;

    vec_t tbl [12];
    int   peak;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 3'd1, 8'd1, 8'd0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'd2, 8'd2, 8'd0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'd3, 8'd3, 8'd0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'd4, 8'd4, 8'd0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 3'd4, 8'd4, 8'd0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 3'd4, 8'd5, 8'd1, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 3'd3, 8'd5, 8'd2, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 3'd3, 8'd0, 8'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 3'd2, 8'd0, 8'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 3'd1, 8'd0, 8'd1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 8'd2, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 8'd2, 1'b0, 1'b1};

        rst = 1'b1; pulse_snd = 1'b0; pulse_rcv = 1'b0; clr_stats = 1'b0;
        m_ts = '0;
        model_clear_stats();

        // Reset values
        do_reset();
        chk("rst_outstanding", 32'(a_out), 32'd0);
        chk("rst_count_snd", 32'(a_cs), 32'd0);
        chk("rst_lat_min", 32'(a_lmin), 32'h0000_FFFF);
        chk("rst_lat_max", 32'(a_lmax), 32'd0);
        chk("rst_flags", 32'({a_es, a_eo, a_et, a_lv}), 32'd0);

        // Single round trip: snd at cycle 10, rcv at cycle 23
        for (int c = 0; c < 24; c++) begin
            cycle(1'(c == 10), 1'(c == 23), 1'b0, 1'b0);
            if (c == 22) chk("lat_valid_early", 32'(a_lv), 32'd0);
        end
        chk("rt_lat_valid", 32'(a_lv), 32'd1);
        chk("rt_lat_last", 32'(a_ll), 32'd13);
        chk("rt_lat_min", 32'(a_lmin), 32'd13);
        chk("rt_lat_max", 32'(a_lmax), 32'd13);
        chk("rt_counts", 32'({a_cs, a_cr}), {16'd1, 16'd1});
        chk("rt_outstanding", 32'(a_out), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rt_lat_valid_pulse", 32'(a_lv), 32'd0);

        // Full/empty/clear corner table
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].snd, tbl[i].rcv, tbl[i].clr, 1'b0);
            chk($sformatf("tbl%0d_outstanding", i), 32'(a_out), 32'(tbl[i].out));
            chk($sformatf("tbl%0d_counts", i), {a_cs, a_cr}, {8'd0, tbl[i].cs, 8'd0, tbl[i].cr});
            chk($sformatf("tbl%0d_flags", i), 32'({a_eo, a_es}), 32'({tbl[i].eo, tbl[i].es}));
        end

        // Reset mid-operation drops entries and overrides inputs
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        chk("midrst_outstanding", 32'(a_out), 32'd0);
        chk("midrst_count_snd", 32'(a_cs), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("midrst_spurious", 32'(a_es), 32'd1);
        chk("midrst_count_rcv", 32'(a_cr), 32'd0);

        // Periodic stream: snd every 8 cycles, 20-cycle loop, 100 pulses
        do_reset();
        peak = 0;
        for (int c = 0; c < 8*99 + 22; c++) begin
            cycle(1'((c % 8 == 0) && (c / 8 < 100)),
                  1'((c >= 20) && ((c - 20) % 8 == 0) && ((c - 20) / 8 < 100)),
                  1'b0, 1'b0);
            if (int'(a_out) > peak) peak = int'(a_out);
        end
        chk("stream_peak", 32'(peak), 32'd3);
        chk("stream_counts", {a_cs, a_cr}, {16'd100, 16'd100});
        chk("stream_lat", {a_lmin, a_lmax}, {16'd20, 16'd20});
        chk("stream_errors", 32'({a_es, a_eo, a_et}), 32'd0);
        chk("stream_lost", 32'(a_cl), 32'd0);

        // Timeout on the short-timeout instance
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c < 16; c++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("to_before_outstanding", 32'(b_out), 32'd1);
        chk("to_before_lost", 32'(b_cl), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("to_lost", 32'(b_cl), 32'd1);
        chk("to_flag", 32'(b_et), 32'd1);
        chk("to_outstanding", 32'(b_out), 32'd0);
        chk("to_no_lat_valid", 32'(b_lv), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("to_late_spurious", 32'(b_es), 32'd1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 99) < 30),
                  1'($urandom_range(0, 99) < ((i < 1500) ? 30 : 12)),
                  1'($urandom_range(0, 99) < 2),
                  1'($urandom_range(0, 199) < 1));
        end

        // Timestamp wrap, then clear with an entry outstanding
        for (int i = 0; i < 70000 && m_ts != 16'hFFFA; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_ts_reached", 32'(m_ts), 32'h0000_FFFA);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c < 10; c++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap_lat_last", 32'(a_ll), 32'd10);
        chk("wrap_lat_valid", 32'(a_lv), 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("wrap_outstanding", 32'(a_out), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_counts", 32'({a_cs, a_cr}), 32'd0);
        chk("clr_lost", 32'(a_cl), 32'd0);
        chk("clr_lat_min", 32'(a_lmin), 32'h0000_FFFF);
        chk("clr_lat_last_max", 32'({a_ll, a_lmax}), 32'd0);
        chk("clr_flags", 32'({a_es, a_eo, a_et, a_lv}), 32'd0);
        chk("clr_outstanding_kept", 32'(a_out), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
